panel_writer: RTL

//  Game-state owner for the 7x6 Score-4 board: accepts column drops, applies gravity,

---
 rtl/panel_writer.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/panel_writer.sv
// panel_writer: owns the 7x6 Score-4 board. It accepts column drops, applies gravity,
// toggles the turn, then samples the external win detector to decide whether the game ends.
// Optional feature: define UNDO_EN to add a one-level undo input.
module panel_writer #(
  parameter logic FIRST_PLAYER = 1'b0,
  parameter int   CHECK_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  new_game,
  input  logic                  move_valid,
  input  logic [2:0]            move_col,
`ifdef UNDO_EN
  input  logic                  undo,
`endif
  input  logic                  win_exists,
  output logic [6:0][5:0][1:0]  panel,
  output logic                  turn,
  output logic                  move_ready,
  output logic                  move_err,
  output logic                  game_over,
  output logic                  draw,
  output logic                  winner,
  output logic [5:0]            move_count,
  output logic [2:0]            last_col,
  output logic [2:0]            last_row
);

  typedef enum logic [1:0] {IDLE, CHECK, OVER} state_t;

  // The counter only has to reach CHECK_CYCLES-1, and CHECK_CYCLES is at most 4.
  localparam logic [1:0] CHK_LAST = 2'(CHECK_CYCLES - 1);

  state_t               state_q, state_d;
  logic [6:0][5:0][1:0] panel_q, panel_d;
  logic                 turn_q, turn_d;
  logic                 err_q, err_d;
  logic                 over_q, over_d;
  logic                 draw_q, draw_d;
  logic                 winner_q, winner_d;
  logic [5:0]           count_q, count_d;
  logic [2:0]           lcol_q, lcol_d;
  logic [2:0]           lrow_q, lrow_d;
  logic [1:0]           chk_q, chk_d;
`ifdef UNDO_EN
  logic                 slot_q, slot_d;
`endif

  logic [5:0][1:0]      col_cells;
  logic                 col_ok;
  logic                 col_full;
  logic [2:0]           drop_row;

  // Select the addressed column and find where a dropped token would land.
  always_comb begin
    col_cells = '0;
    for (int c = 0; c < 7; c++)
      if (move_col == 3'(c)) col_cells = panel_q[c];
    col_ok   = (move_col <= 3'd6);
    col_full = (col_cells[0] != 2'b00);
    // Gravity: the highest-numbered empty row is the lowest free cell.
    drop_row = 3'd0;
    for (int r = 0; r < 6; r++)
      if (col_cells[r] == 2'b00) drop_row = 3'(r);
  end

  // Next-state logic for the game FSM and the board.
  always_comb begin
    state_d  = state_q;
    panel_d  = panel_q;
    turn_d   = turn_q;
    err_d    = 1'b0;
    over_d   = over_q;
    draw_d   = draw_q;
    winner_d = winner_q;
    count_d  = count_q;
    lcol_d   = lcol_q;
    lrow_d   = lrow_q;
    chk_d    = chk_q;
`ifdef UNDO_EN
    slot_d   = slot_q;
`endif
    if (new_game) begin
      state_d  = IDLE;
      panel_d  = '0;
      turn_d   = FIRST_PLAYER;
      over_d   = 1'b0;
      draw_d   = 1'b0;
      winner_d = 1'b0;
      count_d  = '0;
      lcol_d   = '0;
      lrow_d   = '0;
      chk_d    = '0;
`ifdef UNDO_EN
      slot_d   = 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (move_valid) begin
            if (!col_ok || col_full) begin
              err_d = 1'b1;
            end else begin
              panel_d[move_col][drop_row] = turn_q ? 2'b10 : 2'b01;
              turn_d  = ~turn_q;
              count_d = count_q + 6'd1;
              lcol_d  = move_col;
              lrow_d  = drop_row;
              chk_d   = '0;
              state_d = CHECK;
`ifdef UNDO_EN
              slot_d  = 1'b1;
`endif
            end
          end
`ifdef UNDO_EN
          else if (undo) begin
            if (slot_q && count_q != 6'd0) begin
              panel_d[lcol_q][lrow_q] = 2'b00;
              turn_d  = ~turn_q;
              count_d = count_q - 6'd1;
              slot_d  = 1'b0;
            end else begin
              err_d = 1'b1;
            end
          end
`endif
        end
        CHECK: begin
          // win_exists already reflects the new token and the toggled turn,
          // so the mover is ~turn.
          if (chk_q == CHK_LAST) begin
            if (win_exists) begin
              state_d  = OVER;
              over_d   = 1'b1;
              winner_d = ~turn_q;
            end else if (count_q == 6'd42) begin
              state_d = OVER;
              over_d  = 1'b1;
              draw_d  = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            chk_d = chk_q + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Register all game state; reset puts the board into the new-game state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      panel_q  <= '0;
      turn_q   <= FIRST_PLAYER;
      err_q    <= 1'b0;
      over_q   <= 1'b0;
      draw_q   <= 1'b0;
      winner_q <= 1'b0;
      count_q  <= '0;
      lcol_q   <= '0;
      lrow_q   <= '0;
      chk_q    <= '0;
`ifdef UNDO_EN
      slot_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      panel_q  <= panel_d;
      turn_q   <= turn_d;
      err_q    <= err_d;
      over_q   <= over_d;
      draw_q   <= draw_d;
      winner_q <= winner_d;
      count_q  <= count_d;
      lcol_q   <= lcol_d;
      lrow_q   <= lrow_d;
      chk_q    <= chk_d;
`ifdef UNDO_EN
      slot_q   <= slot_d;
`endif
    end
  end

  assign panel      = panel_q;
  assign turn       = turn_q;
  assign move_ready = (state_q == IDLE);
  assign move_err   = err_q;
  assign game_over  = over_q;
  assign draw       = draw_q;
  assign winner     = winner_q;
  assign move_count = count_q;
  assign last_col   = lcol_q;
  assign last_row   = lrow_q;

endmodule
